// File: rtl/jtvigil_iobus.sv
// Z80 I/O-space block: port decode, bank/flip/sound-latch/scroll registers, vblank IRQ latch.
// Registered outputs, one clk after an accepted access. No backpressure: one access accepted per bus cycle.
module jtvigil_iobus #(
  parameter int         SCR_CH   = 2,
  parameter int         SCR_W    = 11,
  parameter int         BANK_W   = 3,
  parameter int         DBUF     = 1,
  parameter logic [7:0] SCR_BASE = 8'h80
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_cen,
  input  logic [7:0]               A,
  input  logic                     iorq_n,
  input  logic                     rd_n,
  input  logic                     wr_n,
  input  logic                     m1_n,
  input  logic [7:0]               cpu_dout,
  output logic [7:0]               io_dout,
  input  logic                     LVBL,
  input  logic                     dip_pause,
  input  logic [5:0]               joystick1,
  input  logic [5:0]               joystick2,
  input  logic [1:0]               start_button,
  input  logic [1:0]               coin_input,
  input  logic                     service,
  input  logic [7:0]               dipsw_a,
  input  logic [7:0]               dipsw_b,
  input  logic                     dip_flip,
  output logic                     int_n,
  output logic                     flip,
  output logic [BANK_W-1:0]        bank,
  output logic                     latch_wr,
  output logic [7:0]               latch_data,
  output logic [SCR_CH*SCR_W-1:0]  scr_pos,
  output logic [2:0]               scr_col
);

  logic             wr_act, rd_act, wr_last, rd_last, wr_stb, rd_stb;
  logic             lvbl_l, vb_edge, ack, flip_bit, pending;
  logic [7:0]       rd_mux;
  logic [SCR_W-1:0] shadow [SCR_CH];
  logic [SCR_W-1:0] vis    [SCR_CH];
  logic             unused_in;

  assign unused_in = coin_input[1];
  assign wr_act  = !iorq_n && !wr_n && m1_n;
  assign rd_act  = !iorq_n && !rd_n && m1_n;
  assign wr_stb  = cpu_cen && wr_act && !wr_last;
  assign rd_stb  = cpu_cen && rd_act && !rd_last;
  assign vb_edge = lvbl_l && !LVBL;
  assign ack     = !iorq_n && !m1_n;
  assign int_n   = ~pending;

  // last-seen flags reset to "active" so an access straddling reset is not taken again
  always_ff @(posedge clk) begin
    lvbl_l <= LVBL;
    if (rst) begin
      wr_last <= 1'b1;
      rd_last <= 1'b1;
    end else if (cpu_cen) begin
      wr_last <= wr_act;
      rd_last <= rd_act;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      latch_wr   <= 1'b0;
      latch_data <= 8'h00;
      flip_bit   <= 1'b0;
      bank       <= '0;
      scr_col    <= 3'd0;
      for (int n = 0; n < SCR_CH; n++) shadow[n] <= '0;
    end else begin
      latch_wr <= 1'b0;
      if (wr_stb) begin
        case (A)
          8'h00: begin
            latch_data <= cpu_dout;
            latch_wr   <= 1'b1;
          end
          8'h01:   flip_bit <= cpu_dout[0];
          8'h04:   bank     <= cpu_dout[BANK_W-1:0];
          default: ;
        endcase
        for (int n = 0; n < SCR_CH; n++) begin
          if (A == SCR_BASE + 8'(2*n))     shadow[n][7:0]       <= cpu_dout;
          if (A == SCR_BASE + 8'(2*n + 1)) shadow[n][SCR_W-1:8] <= cpu_dout[SCR_W-9:0];
        end
        if (A == SCR_BASE + 8'(2*SCR_CH)) scr_col <= {cpu_dout[3], cpu_dout[1:0]};
      end
    end
  end

  // visible copy samples the pre-write shadow on the transfer clk
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < SCR_CH; n++) vis[n] <= '0;
    end else if (DBUF == 0 || vb_edge) begin
      for (int n = 0; n < SCR_CH; n++) vis[n] <= shadow[n];
    end
  end

  always_comb begin
    scr_pos = '0;
    for (int n = 0; n < SCR_CH; n++) scr_pos[n*SCR_W +: SCR_W] = vis[n];
  end

  always_ff @(posedge clk) begin
    if (rst) flip <= dip_flip;
    else     flip <= flip_bit ^ dip_flip;
  end

  always_ff @(posedge clk) begin
    if (rst)                         pending <= 1'b0;
    else if (ack)                    pending <= 1'b0;
    else if (vb_edge && dip_pause)   pending <= 1'b1;
  end

  always_comb begin
    rd_mux = 8'hff;
    case (A)
      8'h00: rd_mux = {4'hf, coin_input[0], service, start_button};
      8'h01: rd_mux = {joystick1[5], 1'b1, joystick1[4], 1'b1, joystick1[3:0]};
      8'h02: rd_mux = {joystick2[5], 1'b1, joystick2[4], 1'b1, joystick2[3:0]};
      8'h03: rd_mux = dipsw_a;
      8'h04: rd_mux = dipsw_b;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)         io_dout <= 8'hff;
    else if (rd_stb) io_dout <= rd_mux;
  end

endmodule

// File: tb/tb_jtvigil_iobus.sv
module tb_jtvigil_iobus;
  logic clk = 1'b0;
  logic rst, cpu_cen, iorq_n, rd_n, wr_n, m1_n, LVBL, dip_pause, service, dip_flip;
  logic [7:0] A, cpu_dout, dipsw_a, dipsw_b;
  logic [5:0] joystick1, joystick2;
  logic [1:0] start_button, coin_input;

  logic [7:0]  io_dout_a, latch_data_a, io_dout_b, latch_data_b;
  logic        int_n_a, flip_a, latch_wr_a, int_n_b, flip_b, latch_wr_b;
  logic [2:0]  bank_a, bank_b, scr_col_a, scr_col_b;
  logic [21:0] scr_pos_a;
  logic [26:0] scr_pos_b;

  int n_cmp = 0, n_fail = 0, latch_cnt = 0;

  // reference model state
  int         m_sh_a[2], m_vis_a[2], m_sh_b[3], m_vis_b[3];
  logic [7:0] m_latch, m_io;
  logic [2:0] m_bank, m_col_a, m_col_b;
  logic       m_flipbit, m_pend;
  int         m_nlatch;

  always #5 clk = ~clk;
  always @(negedge clk) if (latch_wr_a) latch_cnt++;

  jtvigil_iobus dut (
    .clk(clk), .rst(rst), .cpu_cen(cpu_cen), .A(A), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
    .m1_n(m1_n), .cpu_dout(cpu_dout), .io_dout(io_dout_a), .LVBL(LVBL), .dip_pause(dip_pause),
    .joystick1(joystick1), .joystick2(joystick2), .start_button(start_button),
    .coin_input(coin_input), .service(service), .dipsw_a(dipsw_a), .dipsw_b(dipsw_b),
    .dip_flip(dip_flip), .int_n(int_n_a), .flip(flip_a), .bank(bank_a), .latch_wr(latch_wr_a),
    .latch_data(latch_data_a), .scr_pos(scr_pos_a), .scr_col(scr_col_a));

  jtvigil_iobus #(.SCR_CH(3), .SCR_W(9), .DBUF(0)) dut3 (
    .clk(clk), .rst(rst), .cpu_cen(cpu_cen), .A(A), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
    .m1_n(m1_n), .cpu_dout(cpu_dout), .io_dout(io_dout_b), .LVBL(LVBL), .dip_pause(dip_pause),
    .joystick1(joystick1), .joystick2(joystick2), .start_button(start_button),
    .coin_input(coin_input), .service(service), .dipsw_a(dipsw_a), .dipsw_b(dipsw_b),
    .dip_flip(dip_flip), .int_n(int_n_b), .flip(flip_b), .bank(bank_b), .latch_wr(latch_wr_b),
    .latch_data(latch_data_b), .scr_pos(scr_pos_b), .scr_col(scr_col_b));

  // ---------------- reference model ----------------
  task model_reset();
    for (int n = 0; n < 2; n++) begin m_sh_a[n] = 0; m_vis_a[n] = 0; end
    for (int n = 0; n < 3; n++) begin m_sh_b[n] = 0; m_vis_b[n] = 0; end
    m_latch = 8'h00; m_io = 8'hff; m_bank = 3'd0; m_col_a = 3'd0; m_col_b = 3'd0;
    m_flipbit = 1'b0; m_pend = 1'b0; m_nlatch = 0;
  endtask

  task model_write(input logic [7:0] a, input logic [7:0] d);
    if (a == 8'h00) begin m_latch = d; m_nlatch++; end
    if (a == 8'h01) m_flipbit = d[0];
    if (a == 8'h04) m_bank = d[2:0];
    for (int n = 0; n < 2; n++) begin
      if (a == 8'h80 + 2*n)     m_sh_a[n] = (m_sh_a[n] & 'h700) | int'(d);
      if (a == 8'h80 + 2*n + 1) m_sh_a[n] = (m_sh_a[n] & 'hff) | ((int'(d) & 7) << 8);
    end
    for (int n = 0; n < 3; n++) begin
      if (a == 8'h80 + 2*n)     m_sh_b[n] = (m_sh_b[n] & 'h100) | int'(d);
      if (a == 8'h80 + 2*n + 1) m_sh_b[n] = (m_sh_b[n] & 'hff) | ((int'(d) & 1) << 8);
      m_vis_b[n] = m_sh_b[n];
    end
    if (a == 8'h84) m_col_a = {d[3], d[1:0]};
    if (a == 8'h86) m_col_b = {d[3], d[1:0]};
  endtask

  task model_vblank();
    for (int n = 0; n < 2; n++) m_vis_a[n] = m_sh_a[n];
    if (dip_pause) m_pend = 1'b1;
  endtask

  function logic [21:0] exp_pos_a();
    return {11'(m_vis_a[1]), 11'(m_vis_a[0])};
  endfunction

  function logic [26:0] exp_pos_b();
    return {9'(m_vis_b[2]), 9'(m_vis_b[1]), 9'(m_vis_b[0])};
  endfunction

  function logic [7:0] exp_read(input logic [7:0] a);
    case (a)
      8'h00: return {4'hf, coin_input[0], service, start_button};
      8'h01: return {joystick1[5], 1'b1, joystick1[4], 1'b1, joystick1[3:0]};
      8'h02: return {joystick2[5], 1'b1, joystick2[4], 1'b1, joystick2[3:0]};
      8'h03: return dipsw_a;
      8'h04: return dipsw_b;
      default: return 8'hff;
    endcase
  endfunction

  // ---------------- bus stimulus (start and end just after a negedge) ----------------
  task bus_write(input logic [7:0] a, input logic [7:0] d, input int hold, input bit rnd);
    A = a; cpu_dout = d; iorq_n = 1'b0; wr_n = 1'b0; m1_n = 1'b1;
    for (int i = 0; i < hold; i++) begin
      cpu_cen = (rnd && i < hold - 1) ? 1'($urandom % 2) : 1'b1;
      @(negedge clk);
    end
    iorq_n = 1'b1; wr_n = 1'b1; cpu_cen = 1'b1;
    @(negedge clk); @(negedge clk);
  endtask

  task bus_read(input logic [7:0] a, input int hold, input bit rnd);
    A = a; iorq_n = 1'b0; rd_n = 1'b0; m1_n = 1'b1;
    for (int i = 0; i < hold; i++) begin
      cpu_cen = (rnd && i < hold - 1) ? 1'($urandom % 2) : 1'b1;
      @(negedge clk);
    end
    iorq_n = 1'b1; rd_n = 1'b1; cpu_cen = 1'b1;
    @(negedge clk);
  endtask

  task vblank();
    LVBL = 1'b0; @(negedge clk);
    LVBL = 1'b1; @(negedge clk);
  endtask

  task irq_ack();
    iorq_n = 1'b0; m1_n = 1'b0; @(negedge clk);
    iorq_n = 1'b1; m1_n = 1'b1; @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task test_reset();
    rst = 1'b1; dip_flip = 1'b1;
    repeat (3) @(negedge clk);
    model_reset();
    n_cmp++; if (io_dout_a !== 8'hff) begin n_fail++; $display("FAIL rst_io_dout got %h want ff", io_dout_a); end
    n_cmp++; if (int_n_a !== 1'b1) begin n_fail++; $display("FAIL rst_int_n got %b want 1", int_n_a); end
    n_cmp++; if (flip_a !== 1'b1) begin n_fail++; $display("FAIL rst_flip got %b want 1", flip_a); end
    n_cmp++; if (bank_a !== 3'd0 || scr_col_a !== 3'd0) begin n_fail++; $display("FAIL rst_bank_col got %h/%h want 0/0", bank_a, scr_col_a); end
    n_cmp++; if (latch_wr_a !== 1'b0 || latch_data_a !== 8'h00) begin n_fail++; $display("FAIL rst_latch got %b/%h want 0/00", latch_wr_a, latch_data_a); end
    n_cmp++; if (scr_pos_a !== 22'd0 || scr_pos_b !== 27'd0) begin n_fail++; $display("FAIL rst_scr_pos got %h/%h want 0/0", scr_pos_a, scr_pos_b); end
    rst = 1'b0; dip_flip = 1'b0;
    @(negedge clk);
    n_cmp++; if (flip_a !== 1'b0) begin n_fail++; $display("FAIL rst_flip_follow got %b want 0", flip_a); end
    dipsw_a = 8'h5a;
    A = 8'h03; iorq_n = 1'b0; rd_n = 1'b0;
    n_cmp++; if (io_dout_a !== 8'hff) begin n_fail++; $display("FAIL idle_io_dout got %h want ff", io_dout_a); end
    @(negedge clk);
    n_cmp++; if (io_dout_a !== 8'h5a) begin n_fail++; $display("FAIL read_p3_latency got %h want 5a", io_dout_a); end
    iorq_n = 1'b1; rd_n = 1'b1; @(negedge clk);
    dipsw_a = 8'h00; repeat (2) @(negedge clk);
    n_cmp++; if (io_dout_a !== 8'h5a) begin n_fail++; $display("FAIL read_hold got %h want 5a", io_dout_a); end
    m_io = 8'h5a;
  endtask

  task test_dbuf();
    bus_write(8'h80, 8'h34, 1, 0); model_write(8'h80, 8'h34);
    bus_write(8'h81, 8'h05, 1, 0); model_write(8'h81, 8'h05);
    n_cmp++; if (scr_pos_a[10:0] !== 11'h000) begin n_fail++; $display("FAIL dbuf_hold got %h want 000", scr_pos_a[10:0]); end
    n_cmp++; if (scr_pos_b !== exp_pos_b()) begin n_fail++; $display("FAIL nodbuf_immediate got %h want %h", scr_pos_b, exp_pos_b()); end
    vblank(); model_vblank();
    n_cmp++; if (scr_pos_a[10:0] !== 11'h534) begin n_fail++; $display("FAIL dbuf_xfer got %h want 534", scr_pos_a[10:0]); end
    // write landing on the transfer clk
    LVBL = 1'b0; A = 8'h81; cpu_dout = 8'h02; iorq_n = 1'b0; wr_n = 1'b0; cpu_cen = 1'b1;
    @(negedge clk);
    LVBL = 1'b1; iorq_n = 1'b1; wr_n = 1'b1;
    @(negedge clk); @(negedge clk);
    model_vblank(); model_write(8'h81, 8'h02);
    n_cmp++; if (scr_pos_a[10:0] !== 11'h534) begin n_fail++; $display("FAIL coincide_old got %h want 534", scr_pos_a[10:0]); end
    vblank(); model_vblank();
    n_cmp++; if (scr_pos_a[10:0] !== 11'h234) begin n_fail++; $display("FAIL coincide_next got %h want 234", scr_pos_a[10:0]); end
    n_cmp++; if (scr_pos_a !== exp_pos_a()) begin n_fail++; $display("FAIL dbuf_full got %h want %h", scr_pos_a, exp_pos_a()); end
  endtask

  task test_latch_hold();
    latch_cnt = 0;
    bus_write(8'h00, 8'ha5, 6, 0); model_write(8'h00, 8'ha5);
    n_cmp++; if (latch_cnt !== 1) begin n_fail++; $display("FAIL latch_once got %0d want 1", latch_cnt); end
    n_cmp++; if (latch_data_a !== 8'ha5) begin n_fail++; $display("FAIL latch_data got %h want a5", latch_data_a); end
    bus_write(8'h00, 8'h3c, 8, 1); model_write(8'h00, 8'h3c);
    n_cmp++; if (latch_cnt !== 2 || latch_data_a !== 8'h3c) begin n_fail++; $display("FAIL latch_cen got %0d/%h want 2/3c", latch_cnt, latch_data_a); end
  endtask

  task test_irq();
    irq_ack(); m_pend = 1'b0;
    dip_pause = 1'b1; vblank(); model_vblank();
    n_cmp++; if (int_n_a !== 1'b0 || int_n_b !== 1'b0) begin n_fail++; $display("FAIL irq_set got %b/%b want 0", int_n_a, int_n_b); end
    vblank(); model_vblank(); irq_ack(); m_pend = 1'b0;
    n_cmp++; if (int_n_a !== 1'b1) begin n_fail++; $display("FAIL irq_nostack got %b want 1", int_n_a); end
    dip_pause = 1'b0; vblank(); model_vblank();
    n_cmp++; if (int_n_a !== 1'b1) begin n_fail++; $display("FAIL irq_paused got %b want 1", int_n_a); end
    dip_pause = 1'b1; vblank(); model_vblank();
    dip_pause = 1'b0; vblank(); model_vblank();
    n_cmp++; if (int_n_a !== 1'b0) begin n_fail++; $display("FAIL irq_keep got %b want 0", int_n_a); end
    // acknowledge landing on a vblank edge: clear takes priority
    dip_pause = 1'b1;
    LVBL = 1'b0; iorq_n = 1'b0; m1_n = 1'b0; @(negedge clk);
    LVBL = 1'b1; iorq_n = 1'b1; m1_n = 1'b1; @(negedge clk);
    for (int n = 0; n < 2; n++) m_vis_a[n] = m_sh_a[n];
    m_pend = 1'b0;
    n_cmp++; if (int_n_a !== 1'b1) begin n_fail++; $display("FAIL irq_clear_wins got %b want 1", int_n_a); end
  endtask

  task test_params();
    bus_write(8'h85, 8'hff, 1, 0); model_write(8'h85, 8'hff);
    n_cmp++; if (scr_pos_b[26:18] !== 9'h100) begin n_fail++; $display("FAIL ch2_hi got %h want 100", scr_pos_b[26:18]); end
    bus_write(8'h04, 8'h0f, 1, 0); model_write(8'h04, 8'h0f);
    n_cmp++; if (bank_a !== 3'd7 || bank_b !== 3'd7) begin n_fail++; $display("FAIL bank got %0d/%0d want 7", bank_a, bank_b); end
    bus_write(8'h84, 8'h0a, 1, 0); model_write(8'h84, 8'h0a);
    n_cmp++; if (scr_col_a !== 3'b110) begin n_fail++; $display("FAIL scr_col got %b want 110", scr_col_a); end
    n_cmp++; if (scr_col_b !== m_col_b || scr_pos_b !== exp_pos_b()) begin n_fail++; $display("FAIL b_map got %b/%h want %b/%h", scr_col_b, scr_pos_b, m_col_b, exp_pos_b()); end
  endtask

  task test_random();
    logic [7:0] a, d;
    logic [7:0] addrs [11];
    addrs = '{8'h00, 8'h01, 8'h04, 8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h05};
    for (int i = 0; i < 60; i++) begin
      case ($urandom % 5)
        0, 1: begin
          a = ($urandom % 8 == 0) ? 8'($urandom) : addrs[$urandom % 11];
          d = 8'($urandom);
          dip_flip = 1'($urandom);
          bus_write(a, d, 1 + $urandom % 4, 1); model_write(a, d);
        end
        2: begin
          a = ($urandom % 4 == 0) ? 8'($urandom) : 8'($urandom % 6);
          joystick1 = 6'($urandom); joystick2 = 6'($urandom); start_button = 2'($urandom);
          coin_input = 2'($urandom); service = 1'($urandom); dipsw_a = 8'($urandom); dipsw_b = 8'($urandom);
          bus_read(a, 1 + $urandom % 4, 1); m_io = exp_read(a);
        end
        3: begin dip_pause = 1'($urandom); vblank(); model_vblank(); end
        default: begin irq_ack(); m_pend = 1'b0; end
      endcase
      n_cmp++; if (io_dout_a !== m_io || io_dout_b !== m_io) begin n_fail++; $display("FAIL rnd_io_dout[%0d] got %h/%h want %h", i, io_dout_a, io_dout_b, m_io); end
      n_cmp++; if (scr_pos_a !== exp_pos_a() || scr_col_a !== m_col_a) begin n_fail++; $display("FAIL rnd_scr_a[%0d] got %h/%b want %h/%b", i, scr_pos_a, scr_col_a, exp_pos_a(), m_col_a); end
      n_cmp++; if (scr_pos_b !== exp_pos_b() || scr_col_b !== m_col_b) begin n_fail++; $display("FAIL rnd_scr_b[%0d] got %h/%b want %h/%b", i, scr_pos_b, scr_col_b, exp_pos_b(), m_col_b); end
      n_cmp++; if (bank_a !== m_bank || latch_data_a !== m_latch || flip_a !== (m_flipbit ^ dip_flip)) begin n_fail++; $display("FAIL rnd_regs[%0d] got %h/%h/%b want %h/%h/%b", i, bank_a, latch_data_a, flip_a, m_bank, m_latch, m_flipbit ^ dip_flip); end
      n_cmp++; if (int_n_a !== !m_pend || int_n_b !== !m_pend) begin n_fail++; $display("FAIL rnd_int_n[%0d] got %b/%b want %b", i, int_n_a, int_n_b, !m_pend); end
    end
  endtask

  task test_rst_mid();
    A = 8'h00; cpu_dout = 8'h77; iorq_n = 1'b0; wr_n = 1'b0; m1_n = 1'b1; cpu_cen = 1'b1;
    @(negedge clk);
    rst = 1'b1; repeat (2) @(negedge clk);
    rst = 1'b0; latch_cnt = 0; model_reset();
    repeat (3) @(negedge clk);
    iorq_n = 1'b1; wr_n = 1'b1; repeat (2) @(negedge clk);
    n_cmp++; if (latch_cnt !== 0 || latch_data_a !== 8'h00) begin n_fail++; $display("FAIL rst_mid_noaccept got %0d/%h want 0/00", latch_cnt, latch_data_a); end
    bus_write(8'h00, 8'h66, 2, 0); model_write(8'h00, 8'h66);
    n_cmp++; if (latch_cnt !== 1 || latch_data_a !== 8'h66) begin n_fail++; $display("FAIL rst_mid_fresh got %0d/%h want 1/66", latch_cnt, latch_data_a); end
  endtask

  initial begin
    rst = 1'b1; cpu_cen = 1'b1; A = 8'h00; cpu_dout = 8'h00;
    iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
    LVBL = 1'b1; dip_pause = 1'b1; dip_flip = 1'b0; service = 1'b1;
    joystick1 = 6'h3f; joystick2 = 6'h3f; start_button = 2'b11; coin_input = 2'b11;
    dipsw_a = 8'h00; dipsw_b = 8'h00;
    @(negedge clk);
    test_reset();
    test_dbuf();
    test_latch_hold();
    test_irq();
    test_params();
    test_random();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
